// File: rtl/async_fifo_1024x32b.sv
// async_fifo_1024x32b: single-clock FIFO of 2^DEPTH_WIDTH words with registered
// full/empty/almost flags and water levels. Both sides run on clk and share tb_rst.
// Optional build macro ASYNC_FIFO_OUTPUT_REG_EN adds an output register after the
// RAM read stage (read latency 2 instead of 1). Flag timing is the same in both builds.
module async_fifo_1024x32b #(
    parameter int DEPTH_WIDTH      = 12,
    parameter int DATA_WIDTH       = 32,
    parameter int ALMOST_FULL_NUM  = 4092,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   tb_rst,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    output logic [DEPTH_WIDTH:0]   wr_water_level,
    output logic                   almost_full,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_en,
    output logic                   rd_empty,
    output logic [DEPTH_WIDTH:0]   rd_water_level,
    output logic                   almost_empty
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] PTR_ONE    = {{DEPTH_WIDTH{1'b0}}, 1'b1};
    localparam logic [DEPTH_WIDTH:0] FULL_COUNT = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] AF_COUNT   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0] AE_COUNT   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

    // Storage; contents are never cleared, pointers alone define what is valid.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [DEPTH_WIDTH:0]  wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_WIDTH:0]  rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_WIDTH:0]  count_next;
    logic [DEPTH_WIDTH:0]  level_reg;
    logic                  full_reg, empty_reg, afull_reg, aempty_reg;
    logic                  wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] ram_q_reg;

    // Requests are qualified by the registered flags, so a simultaneous write
    // and read on an empty FIFO only writes, and on a full FIFO only reads.
    always_comb begin
        wr_accept   = wr_en && !full_reg;
        rd_accept   = rd_en && !empty_reg;
        wr_ptr_next = wr_accept ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
        rd_ptr_next = rd_accept ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
        count_next  = wr_ptr_next - rd_ptr_next;
    end

    // Pointers and flags; flags are computed from the post-edge count so they
    // describe the FIFO state right after the edge that changed it.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            afull_reg  <= 1'b0;
            aempty_reg <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= count_next;
            full_reg   <= (count_next == FULL_COUNT);
            empty_reg  <= (count_next == '0);
            afull_reg  <= (count_next >= AF_COUNT);
            aempty_reg <= (count_next <= AE_COUNT);
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg[DEPTH_WIDTH-1:0]] <= wr_data;
        end
    end

    // RAM read stage; holds its last word when no read is accepted.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            ram_q_reg <= '0;
        end else if (rd_accept) begin
            ram_q_reg <= mem[rd_ptr_reg[DEPTH_WIDTH-1:0]];
        end
    end

`ifdef ASYNC_FIFO_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] out_q_reg;

    // Extra output register for timing closure; tracks the read stage one cycle later.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            out_q_reg <= '0;
        end else begin
            out_q_reg <= ram_q_reg;
        end
    end

    assign rd_data = out_q_reg;
`else
    assign rd_data = ram_q_reg;
`endif

    assign wr_full        = full_reg;
    assign rd_empty       = empty_reg;
    assign almost_full    = afull_reg;
    assign almost_empty   = aempty_reg;
    assign wr_water_level = level_reg;
    assign rd_water_level = level_reg;

endmodule

// File: tb/tb_async_fifo_1024x32b.sv
// Directed bench for async_fifo_1024x32b: reset, fill to full, drain to empty,
// concurrent write/read at count 1, and reset mid-stream. Read latency follows
// the ASYNC_FIFO_OUTPUT_REG_EN build macro.
module tb_async_fifo_1024x32b;

`ifdef ASYNC_FIFO_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        tb_rst;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_full;
    logic [12:0] wr_water_level;
    logic        almost_full;
    logic [31:0] rd_data;
    logic        rd_en;
    logic        rd_empty;
    logic [12:0] rd_water_level;
    logic        almost_empty;

    int n_cmp  = 0;
    int n_fail = 0;

    async_fifo_1024x32b dut (
        .clk            (clk),
        .tb_rst         (tb_rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks all status outputs against an expected count.
    task automatic check_status(input string tag, input int cnt);
        logic [12:0] exp_lvl;
        exp_lvl = 13'(cnt);
        n_cmp++;
        if (wr_water_level !== exp_lvl || rd_water_level !== exp_lvl) begin
            n_fail++;
            $display("FAIL %s level: got wr=%0d rd=%0d expected %0d", tag, wr_water_level, rd_water_level, cnt);
        end
        n_cmp++;
        if (wr_full !== (cnt == 4096) || rd_empty !== (cnt == 0)) begin
            n_fail++;
            $display("FAIL %s full/empty: got %b/%b expected %b/%b", tag, wr_full, rd_empty, cnt == 4096, cnt == 0);
        end
        n_cmp++;
        if (almost_full !== (cnt >= 4092) || almost_empty !== (cnt <= 4)) begin
            n_fail++;
            $display("FAIL %s almost: got af=%b ae=%b expected af=%b ae=%b", tag, almost_full, almost_empty, cnt >= 4092, cnt <= 4);
        end
    endtask

    task automatic test_reset();
        tb_rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #2;
        check_status("reset_async", 0);
        repeat (3) cycle();
        tb_rst = 1'b0;
        repeat (3) cycle();
        check_status("reset_idle", 0);
        n_cmp++;
        if (rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h expected %h", rd_data, 32'h0);
        end
        $display("test_reset done");
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 4097; k++) begin
            wr_data = 32'hFFFF_FFFF - 32'(k - 1);
            wr_en   = 1'b1;
            cycle();
            check_status($sformatf("fill_%0d", k), (k > 4096) ? 4096 : k);
        end
        wr_en = 1'b0;
        $display("test_fill done: 4097 writes, level %0d", wr_water_level);
    endtask

    task automatic test_drain();
        logic [31:0] exp;
        int idx;
        for (int k = 1; k <= 4097; k++) begin
            rd_en = 1'b1;
            cycle();
            check_status($sformatf("drain_%0d", k), (k > 4096) ? 0 : 4096 - k);
            if (k >= LAT) begin
                idx = k - LAT + 1;
                if (idx > 4096) idx = 4096;
                exp = 32'hFFFF_FFFF - 32'(idx - 1);
                n_cmp++;
                if (rd_data !== exp) begin
                    n_fail++;
                    $display("FAIL drain_data_%0d: got %h expected %h", k, rd_data, exp);
                end
            end
        end
        rd_en = 1'b0;
        repeat (2) cycle();
        n_cmp++;
        if (rd_data !== 32'hFFFF_F000) begin
            n_fail++;
            $display("FAIL drain_hold: got %h expected %h", rd_data, 32'hFFFF_F000);
        end
        $display("test_drain done: last word %h", rd_data);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_seq [0:9];
        wr_data = 32'hA5A5_0000;
        wr_en   = 1'b1;
        cycle();
        check_status("b2b_prime", 1);
        exp_seq[0] = 32'hA5A5_0000;
        for (int i = 1; i < 10; i++) exp_seq[i] = 32'h5A5A_0000 + 32'(i - 1);
        for (int i = 0; i < 10; i++) begin
            wr_data = 32'h5A5A_0000 + 32'(i);
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            cycle();
            check_status($sformatf("b2b_%0d", i), 1);
            if (i >= LAT - 1) begin
                n_cmp++;
                if (rd_data !== exp_seq[i - LAT + 1]) begin
                    n_fail++;
                    $display("FAIL b2b_data_%0d: got %h expected %h", i, rd_data, exp_seq[i - LAT + 1]);
                end
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) cycle();
        n_cmp++;
        if (rd_data !== exp_seq[9]) begin
            n_fail++;
            $display("FAIL b2b_tail: got %h expected %h", rd_data, exp_seq[9]);
        end
        check_status("b2b_end", 1);
        $display("test_back_to_back done");
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 100; k++) begin
            wr_data = 32'h1000_0000 + 32'(k);
            wr_en   = 1'b1;
            cycle();
            if (k == 49) begin
                n_cmp++;
                if (wr_water_level !== 13'd51) begin
                    n_fail++;
                    $display("FAIL midrst_pre: got %0d expected %0d", wr_water_level, 51);
                end
                #2;
                tb_rst = 1'b1;
                wr_en  = 1'b0;
                #1;
                check_status("midrst_async", 0);
                n_cmp++;
                if (rd_data !== 32'h0) begin
                    n_fail++;
                    $display("FAIL midrst_rd_data: got %h expected %h", rd_data, 32'h0);
                end
                cycle();
                tb_rst = 1'b0;
                break;
            end
        end
        wr_data = 32'h1234_5678;
        wr_en   = 1'b1;
        cycle();
        wr_en = 1'b0;
        check_status("midrst_wr", 1);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        repeat (LAT - 1) cycle();
        n_cmp++;
        if (rd_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL midrst_rd: got %h expected %h", rd_data, 32'h1234_5678);
        end
        check_status("midrst_end", 0);
        $display("test_mid_reset done: read %h", rd_data);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
